// File: rtl/mc_qpel_interp_if.sv
// Handshake and pixel bus for mc_qpel_interp: row control, input stream, output stream.
interface mc_qpel_interp_if;
  logic       start;
  logic [1:0] frac;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pix;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pix;
  logic       busy;
  logic       done;

  modport master (
    output start, frac, in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_pix, busy, done
  );

  modport slave (
    input  start, frac, in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_pix, busy, done
  );
endinterface

// File: rtl/mc_qpel_interp.sv
// Horizontal 6-tap half-pel / quarter-pel motion-compensation interpolator, one row per start.
// Quarter-pel averaging is compiled in only when MC_QPEL_AVG_EN is defined.
module mc_qpel_interp #(
  parameter int unsigned ROW_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  mc_qpel_interp_if.slave  bus
);

  localparam int unsigned FILL_N   = 5;
  localparam int unsigned IN_TOTAL = ROW_W + FILL_N;
  localparam int unsigned CNT_W    = $clog2(IN_TOTAL + 1);
  localparam int unsigned ACC_W    = 16;

  localparam logic signed [ACC_W-1:0] K5      = ACC_W'(5);
  localparam logic signed [ACC_W-1:0] K20     = ACC_W'(20);
  localparam logic signed [ACC_W-1:0] K_RND   = ACC_W'(16);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  in_cnt_q, out_cnt_q;
  logic [5:0][7:0]   win_q;
  logic [1:0]        frac_q;
  logic              out_valid_q;
  logic [7:0]        out_pix_q;
  logic              busy_q;
  logic              done_q;

  logic              in_ready_c;
  logic              done_d;
  logic              start_acc;
  logic              in_acc;
  logic              out_acc;
  logic              in_left;
  logic              out_free;

  logic [7:0]        tap_e, tap_f, tap_g, tap_h, tap_i, tap_j;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sh;
  logic [7:0]        b_c;
  logic [7:0]        pix_c;

  function automatic logic signed [ACC_W-1:0] ext(input logic [7:0] v);
    return $signed(ACC_W'(v));
  endfunction

  assign in_left  = (in_cnt_q != CNT_W'(IN_TOTAL));
  assign out_free = !out_valid_q || bus.out_ready;
  assign out_acc  = out_valid_q && bus.out_ready;
  assign in_acc   = in_ready_c && bus.in_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, input handshake and done request
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    done_d     = 1'b0;
    start_acc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !rst) begin
          state_d   = S_FILL;
          start_acc = 1'b1;
        end
      end
      S_FILL: begin
        in_ready_c = !rst && in_left && out_free;
        if (in_ready_c && bus.in_valid && (in_cnt_q == CNT_W'(FILL_N - 1))) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        in_ready_c = !rst && in_left && out_free;
        if (out_acc && (out_cnt_q == CNT_W'(ROW_W - 1))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Taps as seen after shifting the incoming pixel into J
  assign tap_e = win_q[1];
  assign tap_f = win_q[2];
  assign tap_g = win_q[3];
  assign tap_h = win_q[4];
  assign tap_i = win_q[5];
  assign tap_j = bus.in_pix;

  // 6-tap half-pel filter with rounding and clip to 8 bits
  always_comb begin
    acc = ext(tap_e) + ext(tap_j)
        - K5  * (ext(tap_f) + ext(tap_i))
        + K20 * (ext(tap_g) + ext(tap_h))
        + K_RND;
    sh = acc >>> 5;
    if (sh < 0) begin
      b_c = 8'd0;
    end else if (sh > PIX_MAX) begin
      b_c = 8'd255;
    end else begin
      b_c = sh[7:0];
    end
  end

`ifdef MC_QPEL_AVG_EN
  logic [8:0] avg_gb;
  logic [8:0] avg_hb;

  // Quarter-pel phases average the half-pel sample with its nearest integer neighbour
  always_comb begin
    avg_gb = 9'(tap_g) + 9'(b_c) + 9'd1;
    avg_hb = 9'(tap_h) + 9'(b_c) + 9'd1;
    pix_c  = tap_g;
    unique case (frac_q)
      2'd0:    pix_c = tap_g;
      2'd1:    pix_c = 8'(avg_gb >> 1);
      2'd2:    pix_c = b_c;
      default: pix_c = 8'(avg_hb >> 1);
    endcase
  end
`else
  // Without averaging, quarter phases snap to integer (0/1) or half (2/3)
  always_comb begin
    pix_c = tap_g;
    unique case (frac_q)
      2'd0, 2'd1: pix_c = tap_g;
      default:    pix_c = b_c;
    endcase
  end
`endif

  // Datapath: window, counters, latched phase and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      win_q       <= '0;
      frac_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_pix_q   <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= done_d;
      if (start_acc) begin
        frac_q    <= bus.frac;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
        win_q     <= '0;
      end
      if (in_acc) begin
        in_cnt_q <= in_cnt_q + CNT_W'(1);
        win_q    <= {bus.in_pix, win_q[5:1]};
      end
      if (out_acc) begin
        out_cnt_q <= out_cnt_q + CNT_W'(1);
      end
      if (in_acc && (state_q == S_RUN)) begin
        out_valid_q <= 1'b1;
        out_pix_q   <= pix_c;
      end else if (out_acc) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pix   = out_pix_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mc_qpel_interp.sv
// Self-checking bench for mc_qpel_interp: randomized rows scored against a tap-level reference model.
module tb_mc_qpel_interp;

  localparam int ROW_W = 16;
  localparam int N_IN  = ROW_W + 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_qpel_interp_if bus ();

  mc_qpel_interp #(.ROW_W(ROW_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int pix[$];
  int got[$];
  int n_in;
  int n_done;
  bit timed_out;

  // Reference: output k uses input pixels k..k+5 as E..J
  function automatic int model_pix(int k, int fr);
    int e, f, g, h, i, j, b;
    e = pix[k]; f = pix[k+1]; g = pix[k+2];
    h = pix[k+3]; i = pix[k+4]; j = pix[k+5];
    b = (e - 5*f + 20*g + 20*h - 5*i + j + 16) >>> 5;
    if (b < 0) b = 0;
    else if (b > 255) b = 255;
`ifdef MC_QPEL_AVG_EN
    case (fr)
      0:       return g;
      1:       return (g + b + 1) / 2;
      2:       return b;
      default: return (h + b + 1) / 2;
    endcase
`else
    return (fr >= 2) ? b : g;
`endif
  endfunction

  task automatic fill_const(input int v);
    pix.delete();
    for (int k = 0; k < N_IN; k++) pix.push_back(v);
  endtask

  task automatic fill_ramp();
    pix.delete();
    for (int k = 0; k < N_IN; k++) pix.push_back(k);
  endtask

  task automatic fill_rand();
    pix.delete();
    for (int k = 0; k < N_IN; k++) pix.push_back(int'($urandom_range(0, 255)));
  endtask

  // Drives one row (start issued at the current time), collecting accepted outputs into got
  task automatic run_row(input int fr, input bit rnd, input int rst_after,
                         input int mid_at, input int mid_fr);
    int  idx = 0;
    int  cyc = 0;
    bit  prev_stall = 1'b0;
    int  prev_pix = 0;
    bit  mid_sent = 1'b0;
    bit  ir, ov, dn, orr, iv;
    int  op;
    got.delete();
    n_in = 0; n_done = 0; timed_out = 1'b0;
    bus.start = 1'b1; bus.frac = 2'(fr); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.frac  = 2'($urandom_range(0, 3));
      if (rst_after >= 0 && got.size() == rst_after) begin
        rst = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL rst_mid: out_valid=%b busy=%b in_ready=%b, required 0 0 0",
                   bus.out_valid, bus.busy, bus.in_ready);
        end
        return;
      end
      if (mid_at >= 0 && !mid_sent && got.size() == mid_at) begin
        bus.start = 1'b1;
        bus.frac  = 2'(mid_fr);
        mid_sent  = 1'b1;
      end
      iv  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      orr = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.in_valid  = iv;
      bus.in_pix    = (idx < N_IN) ? 8'(pix[idx]) : 8'($urandom_range(0, 255));
      bus.out_ready = orr;
      #1;
      ir = bus.in_ready; ov = bus.out_valid; op = int'(bus.out_pix); dn = bus.done;
      if (prev_stall) begin
        total++;
        if (ov !== 1'b1 || op != prev_pix) begin
          bad++;
          $display("FAIL hold: out_valid=%b out_pix=%0d, required 1 %0d", ov, op, prev_pix);
        end
      end
      if (ov && !orr) begin
        total++;
        if (ir !== 1'b0) begin
          bad++;
          $display("FAIL stall_in_ready: in_ready=%b, required 0", ir);
        end
      end
      if (idx >= N_IN) begin
        total++;
        if (ir !== 1'b0) begin
          bad++;
          $display("FAIL extra_input: in_ready=%b after %0d inputs, required 0", ir, idx);
        end
      end
      if (dn) begin
        n_done++;
        break;
      end
      if (ir && iv) begin
        n_in++;
        idx++;
      end
      if (ov && orr) got.push_back(op);
      prev_stall = ov && !orr;
      prev_pix   = op;
      cyc++;
      if (cyc > 2000) begin
        timed_out = 1'b1;
        total++; bad++;
        $display("FAIL row_timeout: %0d outputs after %0d cycles, required done", got.size(), cyc);
        break;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.frac = 2'd0; bus.in_valid = 1'b1; bus.in_pix = 8'd0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pix !== 8'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_pix=%0d busy=%b done=%b, required all 0",
               bus.in_ready, bus.out_valid, bus.out_pix, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_ready: in_ready=%b busy=%b, required 0 0", bus.in_ready, bus.busy);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_const();
    for (int fr = 0; fr < 4; fr++) begin
      fill_const(100);
      run_row(fr, 1'b0, -1, -1, 0);
      total++;
      if (got.size() != ROW_W || n_in != N_IN || n_done != 1) begin
        bad++;
        $display("FAIL const_counts frac=%0d: outs=%0d ins=%0d dones=%0d, required %0d %0d 1",
                 fr, got.size(), n_in, n_done, ROW_W, N_IN);
      end
      for (int k = 0; k < got.size(); k++) begin
        total++;
        if (got[k] != 100) begin
          bad++;
          $display("FAIL const frac=%0d k=%0d: got %0d, required 100", fr, k, got[k]);
        end
      end
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL done_cycle_busy: busy=%b, required 0", bus.busy);
      end
      @(negedge clk);
      #1;
      total++;
      if (bus.done !== 1'b0) begin
        bad++;
        $display("FAIL done_width: done=%b one cycle later, required 0", bus.done);
      end
    end
  endtask

  task automatic test_ramp(input bit rnd);
    int exp_v;
    for (int fr = 0; fr < 4; fr++) begin
      fill_ramp();
      run_row(fr, rnd, -1, -1, 0);
      total++;
      if (got.size() != ROW_W || n_in != N_IN) begin
        bad++;
        $display("FAIL ramp_counts frac=%0d rnd=%0d: outs=%0d ins=%0d, required %0d %0d",
                 fr, rnd, got.size(), n_in, ROW_W, N_IN);
      end
      for (int k = 0; k < got.size(); k++) begin
`ifdef MC_QPEL_AVG_EN
        exp_v = (fr == 0) ? k + 2 : k + 3;
`else
        exp_v = (fr <= 1) ? k + 2 : k + 3;
`endif
        total++;
        if (got[k] != exp_v) begin
          bad++;
          $display("FAIL ramp frac=%0d rnd=%0d k=%0d: got %0d, required %0d", fr, rnd, k, got[k], exp_v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clip();
    pix.delete();
    for (int k = 0; k < N_IN; k++) pix.push_back(((k % 4) >= 2) ? 255 : 0);
    run_row(2, 1'b0, -1, -1, 0);
    total++;
    if (got.size() != ROW_W) begin
      bad++;
      $display("FAIL clip_count: outs=%0d, required %0d", got.size(), ROW_W);
    end else begin
      total++;
      if (got[0] != 255) begin
        bad++;
        $display("FAIL clip_high: got %0d, required 255", got[0]);
      end
      total++;
      if (got[2] != 0) begin
        bad++;
        $display("FAIL clip_low: got %0d, required 0", got[2]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int fr;
    for (int r = 0; r < 6; r++) begin
      fill_rand();
      fr = int'($urandom_range(0, 3));
      run_row(fr, 1'b1, -1, -1, 0);
      total++;
      if (got.size() != ROW_W || n_in != N_IN) begin
        bad++;
        $display("FAIL rand_counts row=%0d: outs=%0d ins=%0d, required %0d %0d",
                 r, got.size(), n_in, ROW_W, N_IN);
      end
      for (int k = 0; k < got.size(); k++) begin
        total++;
        if (got[k] != model_pix(k, fr)) begin
          bad++;
          $display("FAIL rand row=%0d frac=%0d k=%0d: got %0d, required %0d",
                   r, fr, k, got[k], model_pix(k, fr));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid();
    fill_rand();
    run_row(2, 1'b0, 8, -1, 0);
    fill_rand();
    run_row(1, 1'b1, -1, -1, 0);
    total++;
    if (got.size() != ROW_W || n_in != N_IN) begin
      bad++;
      $display("FAIL post_rst_counts: outs=%0d ins=%0d, required %0d %0d", got.size(), n_in, ROW_W, N_IN);
    end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if (got[k] != model_pix(k, 1)) begin
        bad++;
        $display("FAIL post_rst k=%0d: got %0d, required %0d", k, got[k], model_pix(k, 1));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    fill_rand();
    run_row(0, 1'b0, -1, 5, 2);
    total++;
    if (got.size() != ROW_W || n_in != N_IN) begin
      bad++;
      $display("FAIL mid_start_counts: outs=%0d ins=%0d, required %0d %0d", got.size(), n_in, ROW_W, N_IN);
    end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if (got[k] != model_pix(k, 0)) begin
        bad++;
        $display("FAIL mid_start k=%0d: got %0d, required %0d", k, got[k], model_pix(k, 0));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    fill_rand();
    run_row(3, 1'b0, -1, -1, 0);
    fill_rand();
    run_row(2, 1'b0, -1, -1, 0);
    total++;
    if (got.size() != ROW_W || n_in != N_IN) begin
      bad++;
      $display("FAIL b2b_counts: outs=%0d ins=%0d, required %0d %0d", got.size(), n_in, ROW_W, N_IN);
    end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if (got[k] != model_pix(k, 2)) begin
        bad++;
        $display("FAIL b2b k=%0d: got %0d, required %0d", k, got[k], model_pix(k, 2));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.frac = 2'd0; bus.in_valid = 1'b0; bus.in_pix = 8'd0; bus.out_ready = 1'b1;
    test_reset();
    test_const();
    test_ramp(1'b0);
    test_clip();
    test_ramp(1'b1);
    test_random();
    test_rst_mid();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
